// File: rtl/normal_flit_receiver.sv
// normal_flit_receiver: address-filtering link receiver with a small FIFO toward the router core.
// Also tracks the last kept sender and saturating accept/drop statistics.
package types;
    typedef logic [7:0] node_id_t;
    typedef struct packed {
        node_id_t src_id;
        node_id_t dst_id;
    } header_t;
    typedef struct packed {
        header_t     header;
        logic [31:0] payload;
    } flit_t;
endpackage

module normal_flit_receiver #(
    parameter int             FIFO_DEPTH   = 4,
    parameter types::node_id_t BROADCAST_ID = '1,
    parameter int             CNT_W        = 16
) (
    input  logic            nocclk,
    input  logic            rst,
    input  types::node_id_t this_node_id,
    input  types::flit_t    flit_in,
    input  logic            flit_in_valid,
    output logic            flit_in_ready,
    output types::flit_t    flit_out,
    output logic            flit_out_valid,
    input  logic            flit_out_ready,
    input  logic            flush,
    output types::node_id_t last_src_id,
    output logic            last_src_valid,
    output logic [CNT_W-1:0] accept_count,
    output logic [CNT_W-1:0] drop_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = (CNT_W > CW ? CNT_W : CW) + 1;

    types::flit_t    mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CNT_W-1:0] accept_q, accept_d, drop_q, drop_d;
    types::node_id_t last_src_q, last_src_d;
    logic            last_valid_q, last_valid_d;
    logic            full, in_hs, match, push, pop, filt;
    logic [CW-1:0]   drop_inc;
    logic [SW-1:0]   drop_sum;

    assign full           = count_q == CW'(FIFO_DEPTH);
    assign flit_in_ready  = !full && !flush;
    assign flit_out_valid = count_q != '0;
    assign flit_out       = mem_q[rd_ptr_q];
    assign last_src_id    = last_src_q;
    assign last_src_valid = last_valid_q;
    assign accept_count   = accept_q;
    assign drop_count     = drop_q;

    assign in_hs = flit_in_valid && flit_in_ready;
    assign match = flit_in.header.dst_id == this_node_id || flit_in.header.dst_id == BROADCAST_ID;
    assign push  = in_hs && match;
    assign filt  = in_hs && !match;
    assign pop   = flit_out_valid && flit_out_ready && !flush;

    // Flush drops everything buffered; it never coincides with an input handshake.
    assign drop_inc = flush ? count_q : CW'(filt);
    assign drop_sum = SW'(drop_q) + SW'(drop_inc);

    always_comb begin
        wr_ptr_d     = flush ? '0 : (push ? wr_ptr_q + AW'(1) : wr_ptr_q);
        rd_ptr_d     = flush ? '0 : (pop ? rd_ptr_q + AW'(1) : rd_ptr_q);
        count_d      = flush ? '0 : count_q + CW'(push) - CW'(pop);
        accept_d     = (push && accept_q != '1) ? accept_q + CNT_W'(1) : accept_q;
        drop_d       = (drop_sum > SW'({CNT_W{1'b1}})) ? '1 : drop_sum[CNT_W-1:0];
        last_src_d   = push ? flit_in.header.src_id : last_src_q;
        last_valid_d = push || last_valid_q;
    end

    always_ff @(posedge nocclk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            accept_q     <= '0;
            drop_q       <= '0;
            last_src_q   <= '0;
            last_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            accept_q     <= accept_d;
            drop_q       <= drop_d;
            last_src_q   <= last_src_d;
            last_valid_q <= last_valid_d;
        end
    end

    always_ff @(posedge nocclk) begin
        if (push) mem_q[wr_ptr_q] <= flit_in;
    end
endmodule

// File: tb/tb_normal_flit_receiver.sv
// tb_normal_flit_receiver: scoreboard bench for normal_flit_receiver with a cycle-level reference model.
module tb_normal_flit_receiver;
    import types::*;
    localparam int DEPTH = 4;
    localparam int MAXC  = 15;

    logic       nocclk = 1'b0;
    logic       rst = 1'b1;
    node_id_t   this_node_id = 8'h05;
    flit_t      flit_in = '0;
    logic       flit_in_valid = 1'b0;
    logic       flit_in_ready;
    flit_t      flit_out;
    logic       flit_out_valid;
    logic       flit_out_ready = 1'b0;
    logic       flush = 1'b0;
    node_id_t   last_src_id;
    logic       last_src_valid;
    logic [3:0] accept_count, drop_count;

    normal_flit_receiver #(.FIFO_DEPTH(DEPTH), .CNT_W(4)) dut (
        .nocclk(nocclk), .rst(rst), .this_node_id(this_node_id),
        .flit_in(flit_in), .flit_in_valid(flit_in_valid), .flit_in_ready(flit_in_ready),
        .flit_out(flit_out), .flit_out_valid(flit_out_valid), .flit_out_ready(flit_out_ready),
        .flush(flush), .last_src_id(last_src_id), .last_src_valid(last_src_valid),
        .accept_count(accept_count), .drop_count(drop_count)
    );

    always #5 nocclk = ~nocclk;

    flit_t    sb[$];
    int       acc_e, drp_e, n_chk, n_err;
    node_id_t ls_e;
    bit       lsv_e, took;

    function automatic int sat(int v);
        return v > MAXC ? MAXC : v;
    endfunction

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare DUT against the model, then advance the model across one clock edge.
    task automatic cycle();
        bit m_rdy, match;
        #1;
        m_rdy = sb.size() != DEPTH && !flush;
        check("in_ready", 64'(flit_in_ready), 64'(m_rdy));
        check("out_valid", 64'(flit_out_valid), 64'(sb.size() != 0));
        if (sb.size() != 0) check("flit_out", 64'(flit_out), 64'(sb[0]));
        check("accept_count", 64'(accept_count), 64'(acc_e));
        check("drop_count", 64'(drop_count), 64'(drp_e));
        check("last_src_id", 64'(last_src_id), 64'(ls_e));
        check("last_src_valid", 64'(last_src_valid), 64'(lsv_e));
        took  = flit_in_valid && m_rdy;
        match = flit_in.header.dst_id == 8'h05 || flit_in.header.dst_id == 8'hFF;
        if (rst) begin
            sb.delete();
            acc_e = 0; drp_e = 0; ls_e = '0; lsv_e = 1'b0;
        end else if (flush) begin
            drp_e = sat(drp_e + sb.size());
            sb.delete();
        end else begin
            if (sb.size() != 0 && flit_out_ready) void'(sb.pop_front());
            if (took && match) begin
                sb.push_back(flit_in);
                acc_e = sat(acc_e + 1);
                ls_e  = flit_in.header.src_id;
                lsv_e = 1'b1;
            end else if (took) drp_e = sat(drp_e + 1);
        end
        @(posedge nocclk);
        @(negedge nocclk);
    endtask

    // Offer one flit until accepted; rel >= 0 raises flit_out_ready on that attempt.
    task automatic send(input node_id_t dst, input node_id_t src, input int rel);
        flit_in.header.dst_id = dst;
        flit_in.header.src_id = src;
        flit_in.payload       = $urandom;
        flit_in_valid         = 1'b1;
        took                  = 1'b0;
        for (int i = 0; i < 20 && !took; i++) begin
            if (i == rel) flit_out_ready = 1'b1;
            cycle();
        end
        check("send_accepted", 64'(took), 64'(1));
        flit_in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge nocclk);
        @(negedge nocclk);
        rst = 1'b0;
        // basic filtering: own id, broadcast, foreign id
        flit_out_ready = 1'b1;
        send(8'h05, 8'h11, -1);
        send(8'hFF, 8'h22, -1);
        send(8'h07, 8'h33, -1);
        idle(3);
        // back-pressure: fill, stall, release
        do_reset();
        flit_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h05, 8'(8'h40 + i), -1);
        send(8'h05, 8'h44, 2);
        flit_out_ready = 1'b0;
        send(8'h05, 8'h45, 1);
        idle(6);
        // full with simultaneous pop and push, three wrap rounds
        do_reset();
        for (int r = 0; r < 3; r++) begin
            flit_out_ready = 1'b0;
            for (int i = 0; i < 4; i++) send(8'h05, 8'(8'h50 + 4 * r + i), -1);
            send(8'hFF, 8'(8'h60 + r), 0);
            idle(6);
        end
        // flush with occupancy 3, together with pop and input
        do_reset();
        flit_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(8'h05, 8'(8'h70 + i), -1);
        flush = 1'b1;
        flit_out_ready = 1'b1;
        flit_in_valid = 1'b1;
        flit_in.header.dst_id = 8'h05;
        cycle();
        flush = 1'b0;
        flit_in_valid = 1'b0;
        idle(2);
        // counter saturation, then reset mid-stream
        do_reset();
        flit_out_ready = 1'b1;
        for (int i = 0; i < 17; i++) send(8'h05, 8'(8'h80 + i), -1);
        flit_out_ready = 1'b0;
        send(8'h07, 8'h9A, -1);
        send(8'h05, 8'h9B, -1);
        send(8'h05, 8'h9C, -1);
        flit_in_valid = 1'b1;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        flit_in_valid = 1'b0;
        idle(2);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/normal_flit_receiver.md
# normal_flit_receiver

Receive-side counterpart of the normal flit generator in the router. It accepts hop-level flits from the link, keeps those whose `header.dst_id` names this node or the broadcast ID, and discards all others. Kept flits are buffered in a small FIFO and offered to the router core with a valid/ready handshake. It also records the last sending neighbour and keeps saturating accept/drop statistics.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: buffer entries; power of two, at least 2.
- `BROADCAST_ID`, default all-ones `types::node_id_t`: destination ID that every node accepts.
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `nocclk`  in  1: clock; all logic on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `this_node_id`  in  `types::node_id_t`: this node's ID; treated as static while traffic flows.
- `flit_in`  in  `types::flit_t`: incoming flit from the link.
- `flit_in_valid`  in  1: `flit_in` is valid.
- `flit_in_ready`  out  1: block accepts `flit_in` this cycle.
- `flit_out`  out  `types::flit_t`: FIFO head, unmodified from reception.
- `flit_out_valid`  out  1: FIFO non-empty.
- `flit_out_ready`  in  1: router core consumes the head.
- `flush`  in  1: discard all buffered flits.
- `last_src_id`  out  `types::node_id_t`: `header.src_id` of the most recently kept flit.
- `last_src_valid`  out  1: `last_src_id` has been written since reset.
- `accept_count`  out  `CNT_W`: kept flits; saturating.
- `drop_count`  out  `CNT_W`: discarded flits, both address-filtered and flushed; saturating.

## Operation
- Handshakes:
  - Input handshake is `flit_in_valid && flit_in_ready`.
  - Output handshake is `flit_out_valid && flit_out_ready`.
- `flit_in_ready = !full && !flush`, where `full` is based on the registered occupancy. There is no bypass.
- Address match: `flit_in.header.dst_id == this_node_id || flit_in.header.dst_id == BROADCAST_ID`.
- On an input handshake:
  - If the address matches, write the flit at the write pointer and increment `accept_count`. Update `last_src_id` and set `last_src_valid`.
  - If it does not match, do not write the flit and increment `drop_count`.
  - Either way the flit is consumed; the sender never stalls on a mismatched flit.
- Occupancy count width is clog2(`FIFO_DEPTH`)+1. Read and write pointers wrap modulo `FIFO_DEPTH`.
- Push and pop in the same cycle leave occupancy unchanged and are legal whenever not full. A full FIFO is never pushed.
- `flush` has priority over push and pop:
  - Occupancy and pointers are cleared to 0.
  - `drop_count` increases by the pre-flush occupancy, saturating.
  - A pop presented in that cycle is ignored.
  - Statistics and `last_src_*` are otherwise untouched.
- Counters saturate at 2^`CNT_W`−1 and never wrap.
- No flit field is rewritten; `src_id` and `dst_id` pass through unchanged.

## Timing
- Reset values (cycle after `rst` is sampled high):
  - `flit_out_valid`, `last_src_valid`, `accept_count`, `drop_count` are 0.
  - `last_src_id` is 0 and `flit_out` is don't-care.
  - `flit_in_ready` is 1 unless `flush` is high.
- Reset mid-operation discards buffered flits without counting them as drops.
- Latency: a flit kept at edge N appears on `flit_out` with `flit_out_valid` in cycle N+1. Minimum latency is 1 cycle.
- Throughput is 1 flit/cycle while not full and the core keeps `flit_out_ready` high.
- Full: `flit_in_ready` deasserts the cycle after occupancy reaches `FIFO_DEPTH`. It reasserts the cycle after the first pop.
- Empty: `flit_out_valid` is low, and `flit_out_ready` has no effect.
- `flit_out` is held stable while `flit_out_valid && !flit_out_ready`.
- Counters and `last_src_*` update at the same edge as the input handshake and are visible the next cycle.

## Test plan
- Reset, `FIFO_DEPTH`=4, `this_node_id`=8'h05. Send flits with dst 8'h05, 8'hFF, 8'h07 and `flit_out_ready`=1.
  - Two flits come out, each 1 cycle after its handshake.
  - `accept_count`=2 and `drop_count`=1.
  - `last_src_id` equals the src of the 8'hFF flit.
- Hold `flit_out_ready`=0 and stream 6 matching flits.
  - `flit_in_ready` falls after 4 accepts.
  - Releasing ready delivers 4 then 2 flits, in order, with payloads intact.
- With occupancy 4, assert `flit_out_ready` and `flit_in_valid` together.
  - Pop in cycle 1; push in cycle 2.
  - Pointers wrap correctly over 3 fill/drain rounds.
- With occupancy 3, assert `flush` together with a pop and an input flit.
  - `flit_in_ready`=0 during flush.
  - Next cycle `flit_out_valid`=0 and `drop_count` has increased by 3.
- Preload `CNT_W`=4 and keep 17 flits.
  - `accept_count` sticks at 15.
  - Assert `rst` mid-stream: all outputs return to their reset values the next cycle.
